// File: rtl/led_scroll_controller.sv
// Four-digit seven-segment sequencer: anode multiplexing with a per-slot blank cycle,
// message index generation, and a scroll offset advanced by auto timer or debounced button.
module led_scroll_controller #(
  parameter int DIGIT_TICKS     = 16,
  parameter int FRAMES_PER_STEP = 64,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int MSG_LEN         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       auto_en,
  output logic [3:0] an,
  output logic [3:0] msg_addr,
  output logic [3:0] offset,
  output logic       blank
);
  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int FW = $clog2(FRAMES_PER_STEP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    OFF_LAST   = 4'(MSG_LEN - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]    offset_q, offset_d;
  logic          step_pending_q, step_pending_d;
  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_lvl_q, db_lvl_d;
  logic          db_rise, frame_end, auto_step;
  logic [4:0]    addr_sum;

  always_comb begin
    // Debounce: count consecutive synchronized samples that disagree with the accepted level
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    db_rise  = 1'b0;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = ~db_lvl_q;
        db_rise  = ~db_lvl_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end

    frame_end  = (tick_cnt_q == TICK_LAST) && (digit_q == 2'd3);
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    digit_d    = (tick_cnt_q == TICK_LAST) ? digit_q + 2'd1 : digit_q;

    // A rise coinciding with the boundary only arms the next frame's step
    frame_cnt_d    = frame_cnt_q;
    offset_d       = offset_q;
    step_pending_d = step_pending_q | db_rise;
    auto_step      = 1'b0;
    if (frame_end) begin
      if (auto_en) begin
        if (frame_cnt_q == FRAME_LAST) auto_step = 1'b1;
        else frame_cnt_d = frame_cnt_q + FW'(1);
      end
      if (auto_step || step_pending_q) begin
        offset_d       = (offset_q == OFF_LAST) ? 4'd0 : offset_q + 4'd1;
        frame_cnt_d    = '0;
        step_pending_d = db_rise;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q     <= '0;
      digit_q        <= '0;
      frame_cnt_q    <= '0;
      offset_q       <= '0;
      step_pending_q <= 1'b0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      db_cnt_q       <= '0;
      db_lvl_q       <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      digit_q        <= digit_d;
      frame_cnt_q    <= frame_cnt_d;
      offset_q       <= offset_d;
      step_pending_q <= step_pending_d;
      sync1_q        <= button;
      sync2_q        <= sync1_q;
      db_cnt_q       <= db_cnt_d;
      db_lvl_q       <= db_lvl_d;
    end
  end

  assign addr_sum = {1'b0, offset_q} + {3'b000, digit_q};
  assign msg_addr = 4'(addr_sum % 5'(MSG_LEN));
  assign offset   = offset_q;
  assign blank    = (tick_cnt_q == '0);
  assign an       = blank ? 4'b1111 : ~(4'b1000 >> digit_q);

endmodule

// File: tb/tb_led_scroll_controller.sv
// Bench for led_scroll_controller: per-cycle comparison against a time-based model,
// plus directed scenarios with hand-computed expectations.
module tb_led_scroll_controller;
  localparam int DT = 4, FPS = 2, DB = 3, ML = 16, ML_B = 10;
  localparam int FRAME = 4 * DT;

  logic clk = 1'b0, reset = 1'b1, button = 1'b0, auto_en = 1'b0, button_b = 1'b0;
  logic [3:0] an, msg_addr, offset;
  logic blank;
  logic [3:0] an_b, msg_addr_b, offset_b;
  logic blank_b;

  int checks = 0;
  int errors = 0;
  int t_tb = 0;

  always #5 clk = ~clk;

  led_scroll_controller #(.DIGIT_TICKS(DT), .FRAMES_PER_STEP(FPS), .DEBOUNCE_CYCLES(DB), .MSG_LEN(ML)) dut (
    .clk(clk), .reset(reset), .button(button), .auto_en(auto_en),
    .an(an), .msg_addr(msg_addr), .offset(offset), .blank(blank));

  led_scroll_controller #(.DIGIT_TICKS(DT), .FRAMES_PER_STEP(FPS), .DEBOUNCE_CYCLES(DB), .MSG_LEN(ML_B)) dut_b (
    .clk(clk), .reset(reset), .button(button_b), .auto_en(auto_en),
    .an(an_b), .msg_addr(msg_addr_b), .offset(offset_b), .blank(blank_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s time=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Model: cycle count since reset defines the display position; the offset
  // evolves from frame-boundary events and a sample history of the synchronized button.
  bit m_valid = 1'b0;
  int m_t, m_off, m_frames;
  bit m_pend, m_s1, m_s2, m_db;
  bit m_sq[$];

  always @(posedge clk) begin
    bit rise, all_diff, auto_s;
    if (reset) begin
      m_valid = 1'b1; m_t = 0; m_off = 0; m_frames = 0;
      m_pend = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
      m_sq.delete();
    end else if (m_valid) begin
      rise = 1'b0;
      auto_s = 1'b0;
      m_sq.push_back(m_s2);
      if (m_sq.size() > DB) void'(m_sq.pop_front());
      if (m_sq.size() == DB) begin
        all_diff = 1'b1;
        foreach (m_sq[i]) if (m_sq[i] == m_db) all_diff = 1'b0;
        if (all_diff) begin
          m_db = ~m_db;
          rise = m_db;
          m_sq.delete();
        end
      end
      if (m_t % FRAME == FRAME - 1) begin
        if (auto_en) begin
          m_frames++;
          auto_s = (m_frames == FPS);
        end
        if (auto_s || m_pend) begin
          m_off = (m_off + 1) % ML;
          m_frames = 0;
          m_pend = 1'b0;
        end
      end
      if (rise) m_pend = 1'b1;
      m_s2 = m_s1;
      m_s1 = button;
      m_t++;
    end
  end

  function automatic logic [3:0] exp_an(input int t);
    if (t % DT == 0) return 4'b1111;
    case ((t / DT) % 4)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an", an, exp_an(m_t));
      chk("model_blank", blank, (m_t % DT == 0));
      chk("model_msg_addr", msg_addr, (m_off + (m_t / DT) % 4) % ML);
      chk("model_offset", offset, m_off);
    end
  end

  task automatic wait_to(input int target);
    while (t_tb < target) begin
      @(negedge clk);
      t_tb++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    t_tb = 0;
  endtask

  logic [3:0] an_tab [16] = '{4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hB, 4'hB, 4'hB,
                              4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hE, 4'hE, 4'hE};

  initial begin
    // Free-running display, no scrolling
    auto_en = 1'b0; button = 1'b0;
    do_reset();
    chk("rst_an", an, 4'hF);
    chk("rst_blank", blank, 1);
    chk("rst_offset", offset, 0);
    chk("rst_msg_addr", msg_addr, 0);
    for (int k = 0; k < 16; k++) begin
      wait_to(k);
      chk("seq_an", an, an_tab[k]);
      chk("seq_msg_addr", msg_addr, k / 4);
    end
    wait_to(200);
    chk("idle_offset", offset, 0);

    // Auto scrolling, including wrap for both message lengths
    auto_en = 1'b1;
    do_reset();
    wait_to(31);  chk("auto_off_31", offset, 0);
    wait_to(32);  chk("auto_off_32", offset, 1); chk("auto_addr_32", msg_addr, 1);
    wait_to(36);  chk("auto_addr_36", msg_addr, 2);
    wait_to(40);  chk("auto_addr_40", msg_addr, 3);
    wait_to(44);  chk("auto_addr_44", msg_addr, 4);
    wait_to(63);  chk("auto_off_63", offset, 1);
    wait_to(64);  chk("auto_off_64", offset, 2);
    wait_to(288); chk("b_off_288", offset_b, 9); chk("b_addr_288", msg_addr_b, 9);
    chk("b_an_288", an_b, 4'hF); chk("b_blank_288", blank_b, 1);
    wait_to(292); chk("b_addr_292", msg_addr_b, 0);
    wait_to(296); chk("b_addr_296", msg_addr_b, 1);
    wait_to(300); chk("b_addr_300", msg_addr_b, 2);
    wait_to(320); chk("b_off_320", offset_b, 0);
    wait_to(416); chk("wrap_addr_416", msg_addr, 13);
    wait_to(420); chk("wrap_addr_420", msg_addr, 14);
    wait_to(424); chk("wrap_addr_424", msg_addr, 15);
    wait_to(428); chk("wrap_addr_428", msg_addr, 0);
    wait_to(480); chk("wrap_off_480", offset, 15);
    wait_to(512); chk("wrap_off_512", offset, 0);

    // Button: glitch rejected, held press and second press each step once
    auto_en = 1'b0;
    do_reset();
    wait_to(2);  button = 1'b1;
    wait_to(4);  button = 1'b0;
    wait_to(40); chk("glitch_off", offset, 0); button = 1'b1;
    wait_to(47); chk("press_off_47", offset, 0);
    wait_to(48); chk("press_off_48", offset, 1);
    wait_to(60); button = 1'b0;
    wait_to(64); chk("press_off_64", offset, 1);
    wait_to(70); button = 1'b1;
    wait_to(79); chk("press2_off_79", offset, 1);
    wait_to(80); chk("press2_off_80", offset, 2);
    wait_to(90); button = 1'b0;
    wait_to(120); chk("press2_off_120", offset, 2);

    // Auto step and pending press at the same boundary add one
    auto_en = 1'b1;
    do_reset();
    wait_to(18); button = 1'b1;
    wait_to(26); button = 1'b0;
    wait_to(31); chk("coin_off_31", offset, 0);
    wait_to(32); chk("coin_off_32", offset, 1);
    wait_to(63); chk("coin_off_63", offset, 1);
    wait_to(64); chk("coin_off_64", offset, 2);

    // Debounced rise on the boundary cycle waits one frame
    auto_en = 1'b0;
    do_reset();
    wait_to(43); button = 1'b1;
    wait_to(48); chk("edge_off_48", offset, 0);
    wait_to(55); button = 1'b0;
    wait_to(63); chk("edge_off_63", offset, 0);
    wait_to(64); chk("edge_off_64", offset, 1);

    // Mid-slot reset discards a pending step
    auto_en = 1'b1;
    do_reset();
    wait_to(160); button = 1'b1;
    wait_to(169);
    chk("pre_an", an, 4'b1101);
    chk("pre_offset", offset, 5);
    chk("pre_addr", msg_addr, 7);
    reset = 1'b1; button = 1'b0; auto_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    t_tb = 0;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_blank", blank, 1);
    chk("mid_rst_offset", offset, 0);
    chk("mid_rst_addr", msg_addr, 0);
    wait_to(16); chk("mid_rst_off_16", offset, 0);
    wait_to(40); chk("mid_rst_off_40", offset, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
